// File: rtl/id_stage_pipe_if.sv
// rtl/id_stage_pipe_if.sv - decode-stage bundle: IF/ID handshake, register-file read port, ID/EX outputs, counters
interface id_stage_pipe_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instruction;
    logic [4:0]        rf_src1;
    logic [4:0]        rf_src2;
    logic [DATA_W-1:0] rf_data1;
    logic [DATA_W-1:0] rf_data2;
    logic              hazard_detected;
    logic              ex_ready;
    logic              ex_valid;
    logic [4:0]        ex_dest;
    logic [DATA_W-1:0] ex_val1;
    logic [DATA_W-1:0] ex_val2;
    logic [DATA_W-1:0] ex_reg2;
    logic [3:0]        ex_exe_cmd;
    logic              ex_mem_r_en;
    logic              ex_mem_w_en;
    logic              ex_wb_en;
    logic              ex_is_imm;
    logic              ex_st_or_bne;
    logic              br_taken;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  squash_cnt;

    modport slave (
        input  in_valid, instruction, rf_data1, rf_data2, hazard_detected, ex_ready,
        output in_ready, rf_src1, rf_src2, ex_valid, ex_dest, ex_val1, ex_val2, ex_reg2,
               ex_exe_cmd, ex_mem_r_en, ex_mem_w_en, ex_wb_en, ex_is_imm, ex_st_or_bne,
               br_taken, stall_cnt, squash_cnt
    );

    modport master (
        output in_valid, instruction, rf_data1, rf_data2, hazard_detected, ex_ready,
        input  in_ready, rf_src1, rf_src2, ex_valid, ex_dest, ex_val1, ex_val2, ex_reg2,
               ex_exe_cmd, ex_mem_r_en, ex_mem_w_en, ex_wb_en, ex_is_imm, ex_st_or_bne,
               br_taken, stall_cnt, squash_cnt
    );
endinterface

// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - instruction decode with ID/EX register, hazard bubbles and branch-shadow squash
// Optional: define ID_PERF_CNT_EN to build the stall/squash performance counters.
module id_stage_pipe #(
    parameter int DATA_W = 32,
    parameter int SHADOW = 1,
    parameter int CNT_W  = 16
) (
    input  logic           clk,
    input  logic           rst,
    id_stage_pipe_if.slave bus
);
    typedef enum logic {RUN, SQUASH} state_t;

    typedef struct packed {
        logic              valid;
        logic [4:0]        dest;
        logic [DATA_W-1:0] val1;
        logic [DATA_W-1:0] val2;
        logic [DATA_W-1:0] reg2;
        logic [3:0]        cmd;
        logic              mem_r;
        logic              mem_w;
        logic              wb;
        logic              is_imm;
        logic              st_or_bne;
    } ex_t;

    state_t     state_q, state_d;
    logic [1:0] sq_left_q, sq_left_d;
    ex_t        ex_q, ex_d;
    logic       br_taken_q, br_taken_d;

    logic [5:0] opcode;
    logic [3:0] exe_cmd;
    logic       mem_r, mem_w, wb_en, is_imm, st_or_bne, is_br;
    logic [1:0] br_type;
    logic       br_cond, taken;
    logic       free, squashing, load;
    ex_t        dec_ex;

    assign opcode = bus.instruction[31:26];

    always_comb begin
        exe_cmd   = 4'b0000;
        mem_r     = 1'b0;
        mem_w     = 1'b0;
        wb_en     = 1'b0;
        is_imm    = 1'b0;
        st_or_bne = 1'b0;
        is_br     = 1'b0;
        br_type   = 2'b11;
        case (opcode)
            6'd1:  begin exe_cmd = 4'b0000; wb_en = 1'b1; end
            6'd3:  begin exe_cmd = 4'b0010; wb_en = 1'b1; end
            6'd5:  begin exe_cmd = 4'b0100; wb_en = 1'b1; end
            6'd6:  begin exe_cmd = 4'b0101; wb_en = 1'b1; end
            6'd7:  begin exe_cmd = 4'b0110; wb_en = 1'b1; end
            6'd8:  begin exe_cmd = 4'b0111; wb_en = 1'b1; end
            6'd9:  begin exe_cmd = 4'b1000; wb_en = 1'b1; end
            6'd10: begin exe_cmd = 4'b1000; wb_en = 1'b1; end
            6'd11: begin exe_cmd = 4'b1001; wb_en = 1'b1; end
            6'd12: begin exe_cmd = 4'b1010; wb_en = 1'b1; end
            6'd32: begin exe_cmd = 4'b0000; wb_en = 1'b1; is_imm = 1'b1; end
            6'd33: begin exe_cmd = 4'b0010; wb_en = 1'b1; is_imm = 1'b1; end
            6'd36: begin mem_r = 1'b1; wb_en = 1'b1; is_imm = 1'b1; end
            6'd37: begin mem_w = 1'b1; is_imm = 1'b1; st_or_bne = 1'b1; end
            6'd40: begin is_imm = 1'b1; is_br = 1'b1; br_type = 2'b00; end
            6'd41: begin is_imm = 1'b1; is_br = 1'b1; br_type = 2'b01; st_or_bne = 1'b1; end
            6'd42: begin is_imm = 1'b1; is_br = 1'b1; br_type = 2'b10; end
            default: ;
        endcase
    end

    // Stores and BNE read their second operand from the dest field.
    assign bus.rf_src1 = bus.instruction[20:16];
    assign bus.rf_src2 = st_or_bne ? bus.instruction[25:21] : bus.instruction[15:11];

    always_comb begin
        br_cond = 1'b0;
        case (br_type)
            2'b00:   br_cond = (bus.rf_data1 == '0);
            2'b01:   br_cond = (bus.rf_data1 != bus.rf_data2);
            2'b10:   br_cond = 1'b1;
            default: br_cond = 1'b0;
        endcase
    end
    assign taken = is_br && br_cond;

    assign free         = !ex_q.valid || bus.ex_ready;
    assign squashing    = (state_q == SQUASH);
    assign bus.in_ready = free && (!bus.hazard_detected || squashing);
    assign load         = bus.in_valid && bus.in_ready;

    always_comb begin
        dec_ex           = '0;
        dec_ex.valid     = 1'b1;
        dec_ex.dest      = bus.instruction[25:21];
        dec_ex.val1      = bus.rf_data1;
        dec_ex.val2      = is_imm ? DATA_W'($signed(bus.instruction[15:0])) : bus.rf_data2;
        dec_ex.reg2      = bus.rf_data2;
        dec_ex.cmd       = exe_cmd;
        dec_ex.mem_r     = mem_r;
        dec_ex.mem_w     = mem_w;
        dec_ex.wb        = wb_en;
        dec_ex.is_imm    = is_imm;
        dec_ex.st_or_bne = st_or_bne;
    end

    // A busy ID/EX register freezes everything, including the squash FSM.
    always_comb begin
        state_d    = state_q;
        sq_left_d  = sq_left_q;
        ex_d       = ex_q;
        br_taken_d = br_taken_q;
        if (free) begin
            if (load && squashing) begin
                ex_d       = '0;
                br_taken_d = 1'b0;
                sq_left_d  = sq_left_q - 2'd1;
                if (sq_left_q == 2'd1) state_d = RUN;
            end else if (load) begin
                ex_d       = dec_ex;
                br_taken_d = taken;
                if (taken && SHADOW != 0) begin
                    state_d   = SQUASH;
                    sq_left_d = 2'(SHADOW);
                end
            end else begin
                ex_d       = '0;
                br_taken_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= RUN;
            sq_left_q  <= 2'd0;
            ex_q       <= '0;
            br_taken_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sq_left_q  <= sq_left_d;
            ex_q       <= ex_d;
            br_taken_q <= br_taken_d;
        end
    end

    assign bus.ex_valid     = ex_q.valid;
    assign bus.ex_dest      = ex_q.dest;
    assign bus.ex_val1      = ex_q.val1;
    assign bus.ex_val2      = ex_q.val2;
    assign bus.ex_reg2      = ex_q.reg2;
    assign bus.ex_exe_cmd   = ex_q.cmd;
    assign bus.ex_mem_r_en  = ex_q.mem_r;
    assign bus.ex_mem_w_en  = ex_q.mem_w;
    assign bus.ex_wb_en     = ex_q.wb;
    assign bus.ex_is_imm    = ex_q.is_imm;
    assign bus.ex_st_or_bne = ex_q.st_or_bne;
    assign bus.br_taken     = br_taken_q;

`ifdef ID_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        squash_cnt_d = squash_cnt_q;
        if (free && bus.in_valid && bus.hazard_detected && !squashing && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (load && squashing && squash_cnt_q != '1)
            squash_cnt_d = squash_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q  <= '0;
            squash_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign bus.stall_cnt  = stall_cnt_q;
    assign bus.squash_cnt = squash_cnt_q;
`else
    assign bus.stall_cnt  = '0;
    assign bus.squash_cnt = '0;
`endif
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - directed and randomized checks of id_stage_pipe against a transaction-level model
module tb_id_stage_pipe;
    localparam int DW = 32;
    localparam int SH = 2;
    localparam int CW = 16;
`ifdef ID_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        bit [3:0] cmd;
        bit       mr, mw, wb, im, sb;
    } dec_t;

    typedef struct packed {
        bit          valid;
        bit [4:0]    dest;
        bit [DW-1:0] v1, v2, r2;
        bit [3:0]    cmd;
        bit          mr, mw, wb, im, sb, br;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    id_stage_pipe_if #(.DATA_W(DW), .CNT_W(CW)) bus ();
    id_stage_pipe #(.DATA_W(DW), .SHADOW(SH), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t e;
    int   shadow_left, stall, squash;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Opcode table of the control unit: {exe_cmd, mem_r, mem_w, wb, is_imm, st_or_bne}.
    function automatic dec_t decode(input bit [5:0] op);
        case (op)
            6'd1:  return {4'h0, 5'b00100};
            6'd3:  return {4'h2, 5'b00100};
            6'd5:  return {4'h4, 5'b00100};
            6'd6:  return {4'h5, 5'b00100};
            6'd7:  return {4'h6, 5'b00100};
            6'd8:  return {4'h7, 5'b00100};
            6'd9:  return {4'h8, 5'b00100};
            6'd10: return {4'h8, 5'b00100};
            6'd11: return {4'h9, 5'b00100};
            6'd12: return {4'hA, 5'b00100};
            6'd32: return {4'h0, 5'b00110};
            6'd33: return {4'h2, 5'b00110};
            6'd36: return {4'h0, 5'b10110};
            6'd37: return {4'h0, 5'b01011};
            6'd40: return {4'h0, 5'b00010};
            6'd41: return {4'h0, 5'b00011};
            6'd42: return {4'h0, 5'b00010};
            default: return '0;
        endcase
    endfunction

    function automatic int sat(input int v);
        return (v > (1 << CW) - 1) ? (1 << CW) - 1 : v;
    endfunction

    task automatic cycle(input bit r, input bit iv, input bit [31:0] ins,
                         input bit [DW-1:0] d1, input bit [DW-1:0] d2, input bit hz, input bit er);
        dec_t d;
        bit   free, rdy, taken;
        bit [5:0] op;
        @(negedge clk);
        rst = r; bus.in_valid = iv; bus.instruction = ins;
        bus.rf_data1 = d1; bus.rf_data2 = d2; bus.hazard_detected = hz; bus.ex_ready = er;
        op   = ins[31:26];
        d    = decode(op);
        free = !e.valid || er;
        rdy  = free && (!hz || shadow_left > 0);
        #1;
        check("in_ready", bus.in_ready, rdy);
        check("rf_src1", bus.rf_src1, ins[20:16]);
        check("rf_src2", bus.rf_src2, d.sb ? ins[25:21] : ins[15:11]);
        if (!r) begin
            e = '0; shadow_left = 0; stall = 0; squash = 0;
        end else if (free) begin
            if (iv && rdy) begin
                if (shadow_left > 0) begin
                    e = '0; shadow_left--; squash = sat(squash + 1);
                end else begin
                    taken   = (op == 6'd40 && d1 == 0) || (op == 6'd41 && d1 != d2) || (op == 6'd42);
                    e       = '0;
                    e.valid = 1'b1;
                    e.dest  = ins[25:21];
                    e.v1    = d1;
                    e.r2    = d2;
                    e.v2    = !d.im ? d2 : ins[15] ? (({DW{1'b1}} << 16) | DW'(ins[15:0])) : DW'(ins[15:0]);
                    e.cmd   = d.cmd; e.mr = d.mr; e.mw = d.mw; e.wb = d.wb; e.im = d.im; e.sb = d.sb;
                    e.br    = taken;
                    if (taken) shadow_left = SH;
                end
            end else begin
                e = '0;
                if (iv && hz) stall = sat(stall + 1);
            end
        end
        @(posedge clk);
        #1;
        check("ex_valid", bus.ex_valid, e.valid);
        check("ex_dest", bus.ex_dest, e.dest);
        check("ex_val1", bus.ex_val1, e.v1);
        check("ex_val2", bus.ex_val2, e.v2);
        check("ex_reg2", bus.ex_reg2, e.r2);
        check("ex_exe_cmd", bus.ex_exe_cmd, e.cmd);
        check("ex_ctrl", {bus.ex_mem_r_en, bus.ex_mem_w_en, bus.ex_wb_en, bus.ex_is_imm, bus.ex_st_or_bne},
              {e.mr, e.mw, e.wb, e.im, e.sb});
        check("br_taken", bus.br_taken, e.br);
        check("stall_cnt", bus.stall_cnt, PERF ? stall : 0);
        check("squash_cnt", bus.squash_cnt, PERF ? squash : 0);
    endtask

    bit [5:0] ops [20] = '{6'd0, 6'd1, 6'd3, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11,
                           6'd12, 6'd32, 6'd33, 6'd36, 6'd37, 6'd40, 6'd41, 6'd42, 6'd2, 6'd63};

    initial begin
        bit [31:0] add_i;
        bit [31:0] rins;
        bit [DW-1:0] rd1, rd2;
        exp_t held;
        int s0;
        e = '0; shadow_left = 0; stall = 0; squash = 0;
        bus.in_valid = 1'b0; bus.instruction = '0; bus.rf_data1 = '0; bus.rf_data2 = '0;
        bus.hazard_detected = 1'b0; bus.ex_ready = 1'b1;
        add_i = {6'd1, 5'd3, 5'd4, 5'd5, 11'd0};

        cycle(0, 1, add_i, 32'd11, 32'd22, 0, 1);
        cycle(0, 1, add_i, 32'd11, 32'd22, 0, 1);
        check("rst_ex_valid", bus.ex_valid, 1'b0);
        check("rst_br_taken", bus.br_taken, 1'b0);
        check("rst_exe_cmd", bus.ex_exe_cmd, 4'd0);
        cycle(1, 1, add_i, 32'd11, 32'd22, 0, 1);
        check("first_issue", bus.ex_valid, 1'b1);

        cycle(1, 1, {6'd32, 5'd7, 5'd2, 16'hFFFE}, 32'd1, 32'd2, 0, 1);
        check("imm_val2", bus.ex_val2, 32'hFFFF_FFFE);
        check("imm_dest", bus.ex_dest, 5'd7);
        check("imm_valid", bus.ex_valid, 1'b1);

        s0 = stall;
        for (int i = 0; i < 2; i++) begin
            cycle(1, 1, add_i, 32'd5, 32'd6, 1, 1);
            check("hz_in_ready", bus.in_ready, 1'b0);
            check("hz_bubble_wb", bus.ex_wb_en, 1'b0);
        end
        check("hz_stall_cnt", bus.stall_cnt, PERF ? s0 + 2 : 0);
        cycle(1, 1, add_i, 32'd5, 32'd6, 0, 1);
        check("hz_issue", bus.ex_valid, 1'b1);

        s0 = squash;
        cycle(1, 1, {6'd41, 5'd1, 5'd2, 16'h0010}, 32'd5, 32'd3, 0, 1);
        check("bne_taken", bus.br_taken, 1'b1);
        for (int i = 0; i < 2; i++) begin
            cycle(1, 1, add_i, 32'd7, 32'd8, i == 0, 1);
            check("shadow_bubble", bus.ex_valid, 1'b0);
            check("shadow_br_drop", bus.br_taken, 1'b0);
        end
        check("squash_cnt2", bus.squash_cnt, PERF ? s0 + 2 : 0);
        cycle(1, 1, add_i, 32'd7, 32'd8, 0, 1);
        check("post_shadow_issue", bus.ex_valid, 1'b1);

        held = e;
        s0 = stall;
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, {6'd3, 5'd9, 5'd9, 16'h1234}, 32'd99, 32'd98, i == 1, 0);
            check("bp_val1", bus.ex_val1, held.v1);
            check("bp_valid", bus.ex_valid, 1'b1);
            check("bp_stall_cnt", bus.stall_cnt, PERF ? s0 : 0);
        end

        cycle(1, 1, {6'd42, 26'd0}, 32'd1, 32'd1, 0, 1);
        cycle(1, 1, add_i, 32'd1, 32'd1, 0, 1);
        cycle(0, 1, add_i, 32'd1, 32'd1, 0, 1);
        cycle(1, 1, add_i, 32'd1, 32'd1, 0, 1);
        check("rst_midsquash_issue", bus.ex_valid, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            rins = {ops[$urandom_range(0, 19)], 26'($urandom)};
            rd1  = ($urandom % 4 == 0) ? '0 : DW'($urandom);
            rd2  = ($urandom % 3 == 0) ? rd1 : DW'($urandom);
            cycle(($urandom % 64) != 0, ($urandom % 4) != 0, rins, rd1, rd2,
                  ($urandom % 5) == 0, ($urandom % 4) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

Parametrised successor to the decode stage: decodes one 32-bit instruction per cycle and registers the results into a built-in ID/EX pipeline register. Adds several behaviours on top of plain decode:
- valid/ready handshakes on both sides;
- hazard stalls that hold the instruction and emit a bubble;
- a configurable branch-shadow squash counter.

It sits between the IF/ID register and the EXE stage and drives the register-file read addresses combinationally.

## Interface
- DATA_W, 32, operand/register data width; immediate sign-extended to DATA_W (DATA_W ≥ 16)
- SHADOW, 1, instructions squashed after a taken branch (0–3)
- CNT_W, 16, width of performance counters
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-low reset
- in_valid  input  1  instruction valid from IF/ID
- in_ready  output  1  instruction consumed this cycle
- instruction  input  32  opcode[31:26], dest[25:21], src1[20:16], src2[15:11], imm[15:0]
- rf_src1, rf_src2  output  5  register-file read addresses (combinational)
- rf_data1, rf_data2  input  DATA_W  register-file read data, same cycle
- hazard_detected  input  1  from hazard unit, combinational on rf_src1/rf_src2
- ex_ready  input  1  EXE accepts ex_* this cycle
- ex_valid  output  1  ex_* hold a real instruction
- ex_dest  output  5  destination register
- ex_val1, ex_val2, ex_reg2  output  DATA_W  operand 1, operand 2 (reg or imm), store data
- ex_exe_cmd  output  4  ALU command
- ex_mem_r_en, ex_mem_w_en, ex_wb_en, ex_is_imm, ex_st_or_bne  output  1  control bits
- br_taken  output  1  taken branch/jump, one-cycle pulse aligned to its ex_valid
- stall_cnt, squash_cnt  output  CNT_W  performance counters (see Configuration)

## Operation
- Opcode decode uses the existing Control_unit.
- rf_src1 = src1. rf_src2 = dest when st_or_bne, else src2.
- val2 = sign-extended imm when is_immediate, else rf_data2.
- Branch condition on rf_data1/rf_data2, by branch_type:
  - 00: BEZ, taken when data1 == 0
  - 01: BNE, taken when data1 != data2
  - 10: JMP, always taken
  - 11: not a branch
- Taken requires is_branch_or_jump.
- load = in_valid && in_ready. in_ready = (!ex_valid || ex_ready) && (!hazard_detected || squashing).
- State machine, RUN / SQUASH, with counter sq_left (2 bits):
  - RUN, load of a taken branch: register it with br_taken=1. If SHADOW>0, go to SQUASH with sq_left=SHADOW.
  - SQUASH, each load: the instruction is consumed but written as a bubble (ex_valid=0, all control 0), ignoring hazard_detected. Decrement sq_left; at 1→0 return to RUN.
- RUN, in_valid && hazard_detected && (!ex_valid || ex_ready): write a bubble, hold the instruction (in_ready=0).
- !in_valid and register free: write a bubble.
- ex_valid && !ex_ready: all ex_* and br_taken hold; nothing consumed; no state change.
- A bubble is ex_valid=0 with all ex_* control bits 0, so EXE never writes memory or registers from it.

## Timing
- Reset (rst=0 at edge): ex_valid=0, br_taken=0, all ex_* = 0, state RUN, sq_left=0, counters 0. Reset wins over every other event and aborts an in-progress squash.
- Latency: 1 cycle from load to ex_valid; 0 cycles from instruction to rf_src*.
- br_taken is high exactly while the branch is in the register; it drops with the next register update.
- Back-to-back: one instruction per cycle with ex_ready=1 and no hazards.
- A branch that stalls on a hazard is evaluated only in its load cycle, with forwarded-valid data.
- SHADOW=0: the SQUASH state is never entered.

## Configuration
- ID_PERF_CNT_EN defined:
  - stall_cnt increments on each hazard-bubble cycle.
  - squash_cnt increments on each squashed instruction.
  - Both saturate at all-ones and reset to 0.
- ID_PERF_CNT_EN undefined: counter registers are not built; stall_cnt and squash_cnt are tied to 0.

## Test plan
- Reset: hold rst=0 for 2 cycles with in_valid=1 → ex_valid=0, br_taken=0, ex_exe_cmd=0; first instruction appears one cycle after rst=1.
- Immediate: instruction with imm=16'hFFFE, is_immediate=1, DATA_W=32 → ex_val2=32'hFFFF_FFFE, ex_dest=instruction[25:21], ex_valid=1 next cycle.
- Hazard: hazard_detected=1 for 2 cycles → in_ready=0 and two bubbles with ex_wb_en=0, stall_cnt=2; instruction issues in cycle 3.
- Branch shadow, SHADOW=2: BNE with data1=5, data2=3 → br_taken=1 for 1 cycle; next two instructions produce ex_valid=0, squash_cnt=2; the third issues normally.
- Backpressure: ex_ready=0 for 3 cycles with a valid held → ex_* stable, in_ready=0, no counter change.
- Reset mid-squash: rst=0 while sq_left=1 → after release, the next instruction issues with ex_valid=1.
